// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between I-fetch and load/store, with response watchdog
module mem_port_arbiter #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_mbe,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    output logic [DATA_W/8-1:0] pmem_mbe,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
    state_t state_q, state_d;
    logic last_d_q, last_d_d;
    logic [7:0] wdog_q, wdog_d;
    logic timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic serve_i, serve_d, serving, expire, done, d_req;
    logic [DATA_W-1:0] resp_data;
    always_comb begin
        serve_i       = state_q == SERVE_I;
        serve_d       = state_q == SERVE_D;
        serving       = serve_i | serve_d;
        d_req         = d_read | d_write;
        expire        = serving & ~pmem_resp & (wdog_q == WDOG_LAST);
        done          = serving & ~rst & (pmem_resp | expire);
        resp_data     = pmem_resp ? pmem_rdata : '0;
        i_resp        = done & serve_i;
        d_resp        = done & serve_d;
        i_rdata       = i_resp ? resp_data : i_rdata_q;
        d_rdata       = d_resp ? resp_data : d_rdata_q;
        i_rdata_d     = i_rdata;
        d_rdata_d     = d_rdata;
        pmem_read     = serve_i ? i_read : serve_d ? (d_read & ~d_write) : 1'b0;
        pmem_write    = serve_d & d_write;
        pmem_address  = serve_i ? i_address : serve_d ? d_address : '0;
        pmem_wdata    = serve_d ? d_wdata : '0;
        pmem_mbe      = serve_i ? '1 : serve_d ? d_mbe : '0;
        timeout_err   = timeout_err_q;
        timeout_err_d = timeout_err_q | expire;
        state_d       = state_q;
        last_d_d      = last_d_q;
        wdog_d        = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d  = '0;
                state_d = (i_read & (~d_req | last_d_q)) ? SERVE_I : d_req ? SERVE_D : IDLE;
            end
            SERVE_I, SERVE_D: begin
                state_d  = (pmem_resp | expire) ? RELEASE : state_q;
                last_d_d = (pmem_resp | expire) ? serve_d : last_d_q;
                wdog_d   = (pmem_resp | expire | (&wdog_q)) ? wdog_q : wdog_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_d_q      <= 1'b1;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_d_q      <= last_d_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int TMO = 8;
    logic clk, rst;
    logic i_read, i_resp, d_read, d_write, d_resp;
    logic pmem_read, pmem_write, pmem_resp, timeout_err;
    logic [31:0] i_address, d_address, pmem_address, d_mbe, pmem_mbe;
    logic [255:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
    int total = 0, bad = 0;
    bit armed = 0, auto_mem = 0, rnd = 0, saw_i = 0, saw_d = 0, mem_act = 0;
    int mem_lat = 0;
    int m_who, m_last, m_wait;
    bit m_gap, m_err;
    logic [255:0] m_irdata, m_drdata;
    logic e_to, e_done, e_rd, e_wr;
    logic [31:0] e_addr, e_mbe;
    logic [255:0] e_data, e_wd;

    mem_port_arbiter #(.DATA_W(256), .ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_mbe(d_mbe), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_mbe(pmem_mbe), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .timeout_err(timeout_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: one outstanding transaction, owner 0=none 1=I 2=D, one dead cycle after completion
    always @(posedge clk) begin
        armed = 1;
        if (rst) begin
            m_who = 0; m_gap = 0; m_last = 2; m_wait = 0; m_err = 0;
            m_irdata = '0; m_drdata = '0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_who == 0) begin
            m_wait = 0;
            if (i_read && (!(d_read || d_write) || m_last == 2)) m_who = 1;
            else if (d_read || d_write) m_who = 2;
        end else if (pmem_resp || m_wait == TMO - 1) begin
            if (m_who == 1) m_irdata = pmem_resp ? pmem_rdata : '0;
            else m_drdata = pmem_resp ? pmem_rdata : '0;
            m_err = m_err | !pmem_resp;
            m_last = m_who; m_who = 0; m_gap = 1;
        end else if (m_wait < 255) begin
            m_wait++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            e_to   = (m_who != 0) && !pmem_resp && (m_wait == TMO - 1);
            e_done = (m_who != 0) && !rst && (pmem_resp || e_to);
            e_data = pmem_resp ? pmem_rdata : '0;
            e_rd   = m_who == 1 ? i_read : m_who == 2 ? (d_read && !d_write) : 1'b0;
            e_wr   = (m_who == 2) && d_write;
            e_addr = m_who == 1 ? i_address : m_who == 2 ? d_address : 32'h0;
            e_wd   = m_who == 2 ? d_wdata : '0;
            e_mbe  = m_who == 1 ? 32'hFFFF_FFFF : m_who == 2 ? d_mbe : 32'h0;
            chk("pmem_read", pmem_read, e_rd);
            chk("pmem_write", pmem_write, e_wr);
            chk("pmem_address", pmem_address, e_addr);
            chk("pmem_wdata", pmem_wdata, e_wd);
            chk("pmem_mbe", pmem_mbe, e_mbe);
            chk("i_resp", i_resp, e_done && m_who == 1);
            chk("d_resp", d_resp, e_done && m_who == 2);
            chk("i_rdata", i_rdata, (e_done && m_who == 1) ? e_data : m_irdata);
            chk("d_rdata", d_rdata, (e_done && m_who == 2) ? e_data : m_drdata);
            chk("timeout_err", timeout_err, m_err);
            saw_i = i_resp;
            saw_d = d_resp;
        end
    end

    initial begin
        rst = 1; i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_address = 0;
        d_wdata = 0; d_mbe = 0; pmem_rdata = 0; pmem_resp = 0;
        cyc(); cyc();
        #2;
        chk("rst pmem_read", pmem_read, 0);
        chk("rst i_rdata", i_rdata, 0);
        chk("rst timeout_err", timeout_err, 0);
        rst = 0;
        cyc();
        // single I read, memory answers on the fourth serve cycle
        i_read = 1; i_address = 32'h40;
        #2 chk("t1 idle no request", pmem_read, 0);
        cyc();
        #2;
        chk("t1 grant read", pmem_read, 1);
        chk("t1 grant addr", pmem_address, 32'h40);
        chk("t1 grant mbe", pmem_mbe, 32'hFFFF_FFFF);
        cyc(); cyc(); cyc();
        pmem_resp = 1; pmem_rdata = {8{32'hA5A5_A5A5}};
        #2;
        chk("t1 i_resp", i_resp, 1);
        chk("t1 i_rdata", i_rdata, {8{32'hA5A5_A5A5}});
        cyc();
        pmem_resp = 0; i_read = 0;
        #2;
        chk("t1 release read", pmem_read, 0);
        chk("t1 release hold rdata", i_rdata, {8{32'hA5A5_A5A5}});
        rst = 1; cyc(); cyc(); rst = 0;
        // simultaneous requests after reset alternate I, D, I, D
        i_read = 1; i_address = 32'h1000; d_read = 1; d_address = 32'h2000;
        #2 chk("t2 idle", pmem_read, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            pmem_resp = 1; pmem_rdata = rnd256();
            #2;
            chk("t2 grant", pmem_read, 1);
            chk("t2 owner addr", pmem_address, (k % 2) ? 32'h2000 : 32'h1000);
            chk("t2 i_resp", i_resp, (k % 2) == 0);
            chk("t2 d_resp", d_resp, (k % 2) == 1);
            cyc();
            pmem_resp = 0;
            #2 chk("t2 release", pmem_read, 0);
            cyc();
            #2 chk("t2 idle gap", pmem_read, 0);
        end
        i_read = 0; d_read = 0;
        cyc();
        // masked D write
        d_write = 1; d_address = 32'h100; d_mbe = 32'h0000_000F; d_wdata = {8{32'h1234_5678}};
        cyc();
        #2;
        chk("t3 write", pmem_write, 1);
        chk("t3 no read", pmem_read, 0);
        chk("t3 addr", pmem_address, 32'h100);
        chk("t3 wdata", pmem_wdata, {8{32'h1234_5678}});
        chk("t3 mbe", pmem_mbe, 32'h0000_000F);
        cyc();
        pmem_resp = 1;
        #2 chk("t3 d_resp", d_resp, 1);
        cyc();
        pmem_resp = 0; d_write = 0;
        #2 chk("t3 d_resp pulse", d_resp, 0);
        cyc();
        // read and write together: write wins
        d_read = 1; d_write = 1;
        cyc();
        pmem_resp = 1;
        #2;
        chk("t4 write", pmem_write, 1);
        chk("t4 read", pmem_read, 0);
        chk("t4 d_resp", d_resp, 1);
        cyc();
        pmem_resp = 0; d_read = 0; d_write = 0;
        cyc();
        // memory never answers: forced response on the eighth serve cycle
        i_read = 1; i_address = 32'h80; pmem_rdata = {8{32'hDEAD_BEEF}};
        for (int n = 1; n <= TMO; n++) begin
            cyc();
            #2;
            chk("t5 i_resp", i_resp, n == TMO);
            if (n == TMO) chk("t5 forced rdata", i_rdata, 0);
        end
        cyc();
        i_read = 0;
        #2;
        chk("t5 err set", timeout_err, 1);
        chk("t5 release", pmem_read, 0);
        repeat (5) cyc();
        chk("t5 err sticky", timeout_err, 1);
        rst = 1; cyc(); rst = 0;
        #2 chk("t5 err cleared", timeout_err, 0);
        cyc();
        // reset in the middle of a D read, then a stale response
        d_read = 1; d_address = 32'h300;
        cyc();
        #2 chk("t6 d grant", pmem_read, 1);
        cyc();
        rst = 1;
        cyc();
        rst = 0; i_read = 1; i_address = 32'h400; pmem_resp = 1;
        #2;
        chk("t6 dropped", pmem_read, 0);
        chk("t6 stale d_resp", d_resp, 0);
        cyc();
        pmem_resp = 0;
        #2;
        chk("t6 tie to I", pmem_read, 1);
        chk("t6 tie addr", pmem_address, 32'h400);
        cyc();
        pmem_resp = 1;
        #2 chk("t6 i_resp", i_resp, 1);
        cyc();
        pmem_resp = 0; i_read = 0;
        auto_mem = 1; rnd = 1;
        repeat (3000) begin
            cyc();
            rst = ($urandom_range(0, 499) == 0);
            if (i_read && saw_i) begin
                if ($urandom_range(0, 1) == 0) i_read = 0;
                else i_address = $urandom;
            end else if (!i_read && $urandom_range(0, 3) == 0) begin
                i_read = 1; i_address = $urandom;
            end
            if ((d_read || d_write) && saw_d) begin
                if ($urandom_range(0, 1) == 0) begin d_read = 0; d_write = 0; end
                else begin d_address = $urandom; d_wdata = rnd256(); d_mbe = $urandom; end
            end else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
                mem_lat = $urandom_range(0, 2);
                d_read = mem_lat != 1; d_write = mem_lat != 0;
                d_address = $urandom; d_wdata = rnd256(); d_mbe = $urandom;
            end
            #1;
            if (pmem_read || pmem_write) begin
                if (!mem_act) begin
                    mem_act = 1;
                    mem_lat = ($urandom_range(0, 29) == 0) ? 12 : $urandom_range(0, 5);
                end
                if (mem_lat == 0) begin
                    pmem_resp = 1; pmem_rdata = rnd256(); mem_act = 0;
                end else begin
                    mem_lat--; pmem_resp = 0;
                end
            end else begin
                mem_act = 0;
                pmem_resp = ($urandom_range(0, 7) == 0);
                pmem_rdata = rnd256();
            end
        end
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
